// File: rtl/lsm_fx_pkg.sv
// Q16.16 fixed-point helpers and FSM state type shared by the normal-equation accumulator.
package lsm_fx_pkg;

  localparam int unsigned FX_WIDTH = 32;
  localparam int unsigned FX_FRAC  = 16;

  localparam logic [FX_WIDTH-1:0] FX_ONE = 32'h0001_0000;

  // Saturation limits held at double width so wide intermediates compare directly
  localparam logic signed [2*FX_WIDTH-1:0] FX_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [2*FX_WIDTH-1:0] FX_MIN = -64'sh0000_0000_8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    PACK,
    HOLD
  } acc_state_e;

  // Clamp a double-width signed value into a Q16.16 word; MSB of result flags saturation
  function automatic logic [FX_WIDTH:0] sat_to_width(input logic signed [2*FX_WIDTH-1:0] x);
    logic [FX_WIDTH:0] r;
    if (x > FX_MAX) begin
      r = {1'b1, FX_MAX[FX_WIDTH-1:0]};
    end else if (x < FX_MIN) begin
      r = {1'b1, FX_MIN[FX_WIDTH-1:0]};
    end else begin
      r = {1'b0, x[FX_WIDTH-1:0]};
    end
    return r;
  endfunction

  // Full-precision signed product, arithmetic shift (floor), then clamp; MSB flags saturation
  function automatic logic [FX_WIDTH:0] fx_mul_sat(input logic signed [FX_WIDTH-1:0] a,
                                                   input logic signed [FX_WIDTH-1:0] b);
    logic signed [2*FX_WIDTH-1:0] p;
    p = 64'(a) * 64'(b);
    return sat_to_width(p >>> FX_FRAC);
  endfunction

endpackage

// File: rtl/lsm_sat_accum.sv
// One signed saturating accumulator with enable, synchronous clear and sticky overflow flag.
module lsm_sat_accum
  import lsm_fx_pkg::*;
#(
  parameter int unsigned WIDTH     = FX_WIDTH,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WIDTH-1:0]     din,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0]   sum;
  logic                 sat;
  logic [ACC_WIDTH-1:0] nxt;

  // One guard bit detects signed overflow of the sign-extended add
  always_comb begin
    sum = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH+1-WIDTH){din[WIDTH-1]}}, din};
    sat = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    nxt = sat ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
  end

  // Accumulator register; clear wins over enable
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= nxt;
      ovf <= ovf | sat;
    end
  end

endmodule

// File: rtl/lsm_normal_eq_accum.sv
// Streams (S, Y) samples, builds X^T X and X^T Y for basis {1, S, S^2} in Q16.16,
// and hands the 3x3 system to the downstream solver with a valid/ready pulse.
module lsm_normal_eq_accum
  import lsm_fx_pkg::*;
#(
  parameter int unsigned WIDTH     = FX_WIDTH,
  parameter int unsigned FRAC      = FX_FRAC,
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_s,
  input  logic [WIDTH-1:0]       in_y,
  input  logic                   in_itm,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*WIDTH-1:0]     A_flat,
  output logic [3*WIDTH-1:0]     B_flat,
  output logic [CNT_WIDTH-1:0]   n_itm,
  output logic                   singular,
  output logic                   ovf
);

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam int unsigned      N_ACC = 8;

  acc_state_e state;
  logic [1:0] drain_cnt;
  logic       xfer;

  // Stage 1 products and registers
  logic [WIDTH-1:0] p1_s2, p1_sy;
  logic             p1_s2_sat, p1_sy_sat;
  logic             st1_v, st1_itm, st1_ovf;
  logic [WIDTH-1:0] st1_s, st1_y, st1_s2, st1_sy;

  // Stage 2 products and registers
  logic [WIDTH-1:0] p2_s3, p2_s4, p2_s2y;
  logic             p2_s3_sat, p2_s4_sat, p2_s2y_sat;
  logic             st2_v, st2_itm, st2_ovf;
  logic [WIDTH-1:0] st2_s, st2_y, st2_s2, st2_sy, st2_s3, st2_s4, st2_s2y;

  // Stage 3 accumulation
  logic                 acc_en, acc_clr;
  logic [WIDTH-1:0]     acc_din [N_ACC];
  logic [ACC_WIDTH-1:0] acc_q   [N_ACC];
  logic [N_ACC-1:0]     acc_ovf;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 prod_ovf;

  // Output saturation of each accumulator
  logic [WIDTH-1:0] oval [N_ACC];
  logic [N_ACC-1:0] osat;

  // Handshake: samples only enter while collecting a batch
  always_comb begin
    in_ready = (state == IDLE) || (state == ACCUM);
    xfer     = in_valid && in_ready;
  end

  // First-stage products straight from the input sample
  always_comb begin
    {p1_s2_sat, p1_s2} = fx_mul_sat(in_s, in_s);
    {p1_sy_sat, p1_sy} = fx_mul_sat(in_s, in_y);
  end

  // Pipeline stage 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st1_v   <= 1'b0;
      st1_itm <= 1'b0;
      st1_ovf <= 1'b0;
      st1_s   <= '0;
      st1_y   <= '0;
      st1_s2  <= '0;
      st1_sy  <= '0;
    end else begin
      st1_v <= xfer;
      if (xfer) begin
        st1_itm <= in_itm;
        st1_ovf <= p1_s2_sat | p1_sy_sat;
        st1_s   <= in_s;
        st1_y   <= in_y;
        st1_s2  <= p1_s2;
        st1_sy  <= p1_sy;
      end
    end
  end

  // Second-stage products built from the registered square
  always_comb begin
    {p2_s3_sat,  p2_s3}  = fx_mul_sat(st1_s2, st1_s);
    {p2_s4_sat,  p2_s4}  = fx_mul_sat(st1_s2, st1_s2);
    {p2_s2y_sat, p2_s2y} = fx_mul_sat(st1_s2, st1_y);
  end

  // Pipeline stage 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st2_v   <= 1'b0;
      st2_itm <= 1'b0;
      st2_ovf <= 1'b0;
      st2_s   <= '0;
      st2_y   <= '0;
      st2_s2  <= '0;
      st2_sy  <= '0;
      st2_s3  <= '0;
      st2_s4  <= '0;
      st2_s2y <= '0;
    end else begin
      st2_v <= st1_v;
      if (st1_v) begin
        st2_itm <= st1_itm;
        st2_ovf <= st1_ovf | p2_s3_sat | p2_s4_sat | p2_s2y_sat;
        st2_s   <= st1_s;
        st2_y   <= st1_y;
        st2_s2  <= st1_s2;
        st2_sy  <= st1_sy;
        st2_s3  <= p2_s3;
        st2_s4  <= p2_s4;
        st2_s2y <= p2_s2y;
      end
    end
  end

  // Stage 3 control and accumulator operand routing
  always_comb begin
    acc_en     = st2_v && st2_itm;
    acc_clr    = (state == HOLD) && out_valid && out_ready;
    acc_din[0] = ONE_W;
    acc_din[1] = st2_s;
    acc_din[2] = st2_s2;
    acc_din[3] = st2_s3;
    acc_din[4] = st2_s4;
    acc_din[5] = st2_y;
    acc_din[6] = st2_sy;
    acc_din[7] = st2_s2y;
  end

  for (genvar g = 0; g < N_ACC; g++) begin : g_acc
    lsm_sat_accum #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .din   (acc_din[g]),
      .acc   (acc_q[g]),
      .ovf   (acc_ovf[g])
    );
  end

  // ITM sample counter (saturating) and sticky product-overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n || acc_clr) begin
      cnt      <= '0;
      prod_ovf <= 1'b0;
    end else if (acc_en) begin
      if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      prod_ovf <= prod_ovf | st2_ovf;
    end
  end

  // Clamp each accumulator back to a Q16.16 word
  always_comb begin
    for (int unsigned i = 0; i < N_ACC; i++) begin
      {osat[i], oval[i]} = sat_to_width(64'(signed'(acc_q[i])));
    end
  end

  // Batch control FSM with registered solver-facing outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      singular  <= 1'b0;
      ovf       <= 1'b0;
      n_itm     <= '0;
      A_flat    <= '0;
      B_flat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          drain_cnt <= '0;
          if (xfer) begin
            state <= in_last ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          drain_cnt <= '0;
          if (xfer && in_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd1) begin
            state <= PACK;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        PACK: begin
          A_flat    <= {oval[4], oval[3], oval[2],
                        oval[3], oval[2], oval[1],
                        oval[2], oval[1], oval[0]};
          B_flat    <= {oval[7], oval[6], oval[5]};
          n_itm     <= cnt;
          singular  <= (cnt < CNT_WIDTH'(3));
          ovf       <= prod_ovf | (|acc_ovf) | (|osat);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_normal_eq_accum.sv
// Directed, table-driven bench for the normal-equation accumulator.
module tb_lsm_normal_eq_accum;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_s;
  logic [W-1:0]   in_y;
  logic           in_itm;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [9*W-1:0] A_flat;
  logic [3*W-1:0] B_flat;
  logic [15:0]    n_itm;
  logic           singular;
  logic           ovf;

  lsm_normal_eq_accum #(
    .WIDTH     (32),
    .FRAC      (16),
    .ACC_WIDTH (48),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_y      (in_y),
    .in_itm    (in_itm),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_flat    (A_flat),
    .B_flat    (B_flat),
    .n_itm     (n_itm),
    .singular  (singular),
    .ovf       (ovf)
  );

  typedef struct {
    int              ns;
    logic [3:0][31:0] s;
    logic [3:0][31:0] y;
    logic [3:0]       itm;
    logic [8:0][31:0] a;
    logic [2:0][31:0] b;
    logic [31:0]      n;
    logic [31:0]      sing;
    logic [31:0]      ov;
  } vec_t;

  vec_t tbl [7];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_smp(input int idx, input int k, input logic [31:0] s,
                         input logic [31:0] y, input logic itm);
    tbl[idx].s[k]   = s;
    tbl[idx].y[k]   = y;
    tbl[idx].itm[k] = itm;
    if (k + 1 > tbl[idx].ns) tbl[idx].ns = k + 1;
  endtask

  task automatic set_exp(input int idx,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                         input logic [31:0] a6, input logic [31:0] a7, input logic [31:0] a8,
                         input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                         input logic [31:0] n, input logic [31:0] sing, input logic [31:0] ov);
    tbl[idx].a[0] = a0; tbl[idx].a[1] = a1; tbl[idx].a[2] = a2;
    tbl[idx].a[3] = a3; tbl[idx].a[4] = a4; tbl[idx].a[5] = a5;
    tbl[idx].a[6] = a6; tbl[idx].a[7] = a7; tbl[idx].a[8] = a8;
    tbl[idx].b[0] = b0; tbl[idx].b[1] = b1; tbl[idx].b[2] = b2;
    tbl[idx].n    = n;
    tbl[idx].sing = sing;
    tbl[idx].ov   = ov;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] y, input logic itm, input logic last);
    in_s     = s;
    in_y     = y;
    in_itm   = itm;
    in_last  = last;
    in_valid = 1'b1;
    chk("in_ready_on_send", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_outputs(input int idx);
    for (int i = 0; i < 9; i++)
      chk($sformatf("b%0d_A%0d", idx, i), A_flat[i*W +: W], tbl[idx].a[i]);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b%0d_B%0d", idx, i), B_flat[i*W +: W], tbl[idx].b[i]);
    chk($sformatf("b%0d_n_itm", idx), 32'(n_itm), tbl[idx].n);
    chk($sformatf("b%0d_singular", idx), 32'(singular), tbl[idx].sing);
    chk($sformatf("b%0d_ovf", idx), 32'(ovf), tbl[idx].ov);
  endtask

  task automatic run_batch(input int idx);
    int lat;
    for (int k = 0; k < tbl[idx].ns; k++)
      send(tbl[idx].s[k], tbl[idx].y[k], tbl[idx].itm[k], (k == tbl[idx].ns - 1));
    wait_out(lat);
    chk($sformatf("b%0d_latency", idx), lat, 32'd3);
    check_outputs(idx);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_ovf", 32'(ovf), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_A_nonzero"}, 32'(|A_flat), 32'd0);
    chk({tag, "_B_nonzero"}, 32'(|B_flat), 32'd0);
    chk({tag, "_n_itm"}, 32'(n_itm), 32'd0);
    chk({tag, "_singular"}, 32'(singular), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    // Batch table: samples and hand-computed Q16.16 expectations
    for (int i = 0; i < 7; i++) tbl[i].ns = 0;
    // 0: quadratic fit data
    set_smp(0, 0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    set_smp(0, 1, 32'h0002_0000, 32'h0004_0000, 1'b1);
    set_smp(0, 2, 32'h0003_0000, 32'h0009_0000, 1'b1);
    set_exp(0, 32'h30000, 32'h60000, 32'hE0000, 32'h60000, 32'hE0000, 32'h240000,
            32'hE0000, 32'h240000, 32'h620000, 32'hE0000, 32'h240000, 32'h620000, 3, 0, 0);
    // 1: same data with an out-of-the-money sample in the middle
    set_smp(1, 0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    set_smp(1, 1, 32'h0005_0000, 32'h0007_0000, 1'b0);
    set_smp(1, 2, 32'h0002_0000, 32'h0004_0000, 1'b1);
    set_smp(1, 3, 32'h0003_0000, 32'h0009_0000, 1'b1);
    set_exp(1, 32'h30000, 32'h60000, 32'hE0000, 32'h60000, 32'hE0000, 32'h240000,
            32'hE0000, 32'h240000, 32'h620000, 32'hE0000, 32'h240000, 32'h620000, 3, 0, 0);
    // 2: S=127 saturates S^3 and S^4
    set_smp(2, 0, 32'h007F_0000, 32'h0001_0000, 1'b1);
    set_exp(2, 32'h10000, 32'h7F0000, 32'h3F010000, 32'h7F0000, 32'h3F010000, 32'h7FFFFFFF,
            32'h3F010000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h10000, 32'h7F0000, 32'h3F010000, 1, 1, 1);
    // 3: nothing in the money
    set_smp(3, 0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    set_smp(3, 1, 32'h0002_0000, 32'h0002_0000, 1'b0);
    set_exp(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // 4: single sample (2.0, 2.0)
    set_smp(4, 0, 32'h0002_0000, 32'h0002_0000, 1'b1);
    set_exp(4, 32'h10000, 32'h20000, 32'h40000, 32'h20000, 32'h40000, 32'h80000,
            32'h40000, 32'h80000, 32'h100000, 32'h20000, 32'h40000, 32'h80000, 1, 1, 0);
    // 5: negative values (-1.5, 2.0), (0.5, -1.0)
    set_smp(5, 0, 32'hFFFE_8000, 32'h0002_0000, 1'b1);
    set_smp(5, 1, 32'h0000_8000, 32'hFFFF_0000, 1'b1);
    set_exp(5, 32'h20000, 32'hFFFF0000, 32'h28000, 32'hFFFF0000, 32'h28000, 32'hFFFCC000,
            32'h28000, 32'hFFFCC000, 32'h52000, 32'h10000, 32'hFFFC8000, 32'h44000, 2, 1, 0);
    // 6: one-LSB operands: floor truncation gives S*Y = -1 LSB, S^2 = 0
    set_smp(6, 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    set_exp(6, 32'h10000, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0,
            0, 0, 0, 32'h1, 32'hFFFFFFFF, 0, 1, 1, 0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_s      = '0;
    in_y      = '0;
    in_itm    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("por");

    for (int i = 0; i < 7; i++) begin
      run_batch(i);
      release_out();
    end

    // Backpressure: outputs hold while the solver is busy, no samples accepted
    run_batch(0);
    in_s     = 32'h0005_0000;
    in_y     = 32'h0005_0000;
    in_itm   = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_A_stable", c), 32'(A_flat === tbl[0].a), 32'd1);
      chk($sformatf("bp%0d_B_stable", c), 32'(B_flat === tbl[0].b), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_out();
    run_batch(4);
    release_out();

    // Reset in the middle of a batch, then a clean fit batch
    send(32'h0005_0000, 32'h0007_0000, 1'b1, 1'b0);
    send(32'h0004_0000, 32'h0004_0000, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("mid");
    run_batch(0);
    release_out();

    // Reset while holding results for the solver
    run_batch(2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
